// File: rtl/afifo_pkg.sv
// afifo_pkg: Gray-code helpers and depth helper shared by both FIFO clock domains.
// Functions work on 32-bit values. Callers zero-extend narrower pointers and truncate the result.
package afifo_pkg;
  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction
endpackage

// File: rtl/sync_chain.sv
// sync_chain: STAGES-deep flop chain that brings a bus into the clk domain.
// Ports:
//   clk   - destination clock
//   reset - asynchronous, active-low
//   d     - asynchronous input bus
//   q     - last synchroniser stage
module sync_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) stage_q <= '0;
    else stage_q <= {stage_q[STAGES-2:0], d};
  assign q = stage_q[STAGES-1];
endmodule

// File: rtl/afifo_wr_ctrl.sv
// afifo_wr_ctrl: write-domain pointer, flag and overflow control of the dual-clock FIFO.
// Ports:
//   wr_clk, reset    - write clock; asynchronous, active-low reset
//   wr_en            - producer write request
//   rd_ptr_gray      - Gray read pointer from the read domain
//   clr_overflow     - synchronous clear of overflow
//   mem_we/mem_waddr - memory write strobe and address
//   wr_ptr_gray      - registered Gray write pointer to the read domain
//   full/almost_full/wr_level/overflow - status
module afifo_wr_ctrl
  import afifo_pkg::*;
#(
  parameter int ADDR_W       = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 14
) (
  input  logic              wr_clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rd_ptr_gray,
  input  logic              clr_overflow,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow
);
  localparam int PW = ADDR_W + 1;
  logic [PW-1:0] wb_q, wb_d, wg_q, wg_d, rs, rb;
  logic          ovf_q, ovf_d;
  sync_chain #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rd_sync (
    .clk  (wr_clk),
    .reset(reset),
    .d    (rd_ptr_gray),
    .q    (rs)
  );
  always_comb begin
    rb          = PW'(gray2bin(32'(rs)));
    wr_level    = wb_q - rb;
    // Full when the pointers match except for the two MSBs, which are inverted in Gray code.
    full        = wg_q == {~rs[ADDR_W:ADDR_W-1], rs[ADDR_W-2:0]};
    almost_full = wr_level >= PW'(AFULL_THRESH);
    mem_we      = wr_en & ~full;
    wb_d        = wb_q + PW'(mem_we);
    // The Gray pointer comes from the next binary value, so it never lags wb.
    wg_d        = PW'(bin2gray(32'(wb_d)));
    // Set wins over clear.
    ovf_d       = (wr_en & full) | (ovf_q & ~clr_overflow);
  end
  always_ff @(posedge wr_clk or negedge reset)
    if (!reset) begin
      wb_q  <= '0;
      wg_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      wb_q  <= wb_d;
      wg_q  <= wg_d;
      ovf_q <= ovf_d;
    end
  assign mem_waddr   = wb_q[ADDR_W-1:0];
  assign wr_ptr_gray = wg_q;
  assign overflow    = ovf_q;
endmodule
